// File: rtl/lsq_pkg.sv
// Shared defaults and packed-entry layout for the load/store station.
// Offsets are functions of the widths so non-default instances share one layout.
package lsq_pkg;
  localparam int LSQ_DEPTH = 8;
  localparam int LSQ_ROB_W = 4;
  localparam int LSQ_PR_W  = 6;
  localparam int LSQ_IMM_W = 16;

  localparam int OFF_ISLW = 0;
  localparam int OFF_ISST = 1;
  localparam int OFF_ROB  = 2;

  function automatic int off_p_rd(int rob_w);
    return OFF_ROB + rob_w;
  endfunction
  function automatic int off_p_rs(int rob_w, int pr_w);
    return off_p_rd(rob_w) + pr_w;
  endfunction
  function automatic int off_v_rs(int rob_w, int pr_w);
    return off_p_rs(rob_w, pr_w) + pr_w;
  endfunction
  function automatic int off_p_rt(int rob_w, int pr_w);
    return off_v_rs(rob_w, pr_w) + 1;
  endfunction
  function automatic int off_v_rt(int rob_w, int pr_w);
    return off_p_rt(rob_w, pr_w) + pr_w;
  endfunction
  function automatic int off_immed(int rob_w, int pr_w);
    return off_v_rt(rob_w, pr_w) + 1;
  endfunction
  function automatic int off_killed(int rob_w, int pr_w, int imm_w);
    return off_immed(rob_w, pr_w) + imm_w;
  endfunction
  function automatic int entry_w(int rob_w, int pr_w, int imm_w);
    return off_killed(rob_w, pr_w, imm_w) + 1;
  endfunction

  localparam int OFF_P_RD   = off_p_rd(LSQ_ROB_W);
  localparam int OFF_P_RS   = off_p_rs(LSQ_ROB_W, LSQ_PR_W);
  localparam int OFF_V_RS   = off_v_rs(LSQ_ROB_W, LSQ_PR_W);
  localparam int OFF_P_RT   = off_p_rt(LSQ_ROB_W, LSQ_PR_W);
  localparam int OFF_V_RT   = off_v_rt(LSQ_ROB_W, LSQ_PR_W);
  localparam int OFF_IMMED  = off_immed(LSQ_ROB_W, LSQ_PR_W);
  localparam int OFF_KILLED = off_killed(LSQ_ROB_W, LSQ_PR_W, LSQ_IMM_W);
endpackage

// File: rtl/lsq_station_if.sv
// Dispatch, CDB, recovery and head-issue signals of the load/store station.
interface lsq_station_if
  import lsq_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH,
  parameter int ROB_W = LSQ_ROB_W,
  parameter int PR_W  = LSQ_PR_W,
  parameter int IMM_W = LSQ_IMM_W
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             isDispatch;
  logic [ROB_W-1:0] rob_num_dp;
  logic [PR_W-1:0]  p_rd_new, p_rs, p_rt;
  logic             read_rs, read_rt, v_rs, v_rt;
  logic             mem_ren, mem_wen;
  logic [IMM_W-1:0] immed;
  logic             stall_hazard, recover;
  logic [ROB_W-1:0] rob_num_rec;
  logic             complete, RegDest_compl;
  logic [PR_W-1:0]  p_rd_compl;

  logic [PR_W-1:0]  p_rs_out, p_rt_out, p_rd_out;
  logic [IMM_W-1:0] immed_out;
  logic [ROB_W-1:0] rob_num_out;
  logic             RegDest_out, mem_ren_out, mem_wen_out;
  logic             issue, lss_full, lss_empty;
  logic [CW-1:0]    lss_count;

  modport master (
    output isDispatch, rob_num_dp, p_rd_new, p_rs, p_rt, read_rs, read_rt, v_rs, v_rt,
           mem_ren, mem_wen, immed, stall_hazard, recover, rob_num_rec,
           complete, p_rd_compl, RegDest_compl,
    input  p_rs_out, p_rt_out, p_rd_out, immed_out, rob_num_out,
           RegDest_out, mem_ren_out, mem_wen_out, issue, lss_full, lss_empty, lss_count
  );
  modport slave (
    input  isDispatch, rob_num_dp, p_rd_new, p_rs, p_rt, read_rs, read_rt, v_rs, v_rt,
           mem_ren, mem_wen, immed, stall_hazard, recover, rob_num_rec,
           complete, p_rd_compl, RegDest_compl,
    output p_rs_out, p_rt_out, p_rd_out, immed_out, rob_num_out,
           RegDest_out, mem_ren_out, mem_wen_out, issue, lss_full, lss_empty, lss_count
  );
endinterface

// File: rtl/lsq_match_cmp.sv
// Per-entry CDB wakeup and recovery-tag match.
module lsq_match_cmp #(
  parameter int ROB_W = 4,
  parameter int PR_W  = 6
) (
  input  logic             vld,
  input  logic [PR_W-1:0]  p_rs,
  input  logic [PR_W-1:0]  p_rt,
  input  logic [ROB_W-1:0] rob,
  input  logic             cdb_en,
  input  logic [PR_W-1:0]  p_rd_compl,
  input  logic             recover,
  input  logic [ROB_W-1:0] rob_num_rec,
  output logic             wake_rs,
  output logic             wake_rt,
  output logic             kill
);
  assign wake_rs = vld & cdb_en & (p_rs == p_rd_compl);
  assign wake_rt = vld & cdb_en & (p_rt == p_rd_compl);
  assign kill    = vld & recover & (rob == rob_num_rec);
endmodule

// File: rtl/lsq_station.sv
// In-order load/store reservation FIFO with CDB wakeup, tag flush and zero-latency head issue.
module lsq_station
  import lsq_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH,
  parameter int ROB_W = LSQ_ROB_W,
  parameter int PR_W  = LSQ_PR_W,
  parameter int IMM_W = LSQ_IMM_W
) (
  input logic         clk,
  input logic         rst,
  lsq_station_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int O_PRD = off_p_rd(ROB_W);
  localparam int O_PRS = off_p_rs(ROB_W, PR_W);
  localparam int O_VRS = off_v_rs(ROB_W, PR_W);
  localparam int O_PRT = off_p_rt(ROB_W, PR_W);
  localparam int O_VRT = off_v_rt(ROB_W, PR_W);
  localparam int O_IMM = off_immed(ROB_W, PR_W);
  localparam int O_KIL = off_killed(ROB_W, PR_W, IMM_W);
  localparam int EW    = entry_w(ROB_W, PR_W, IMM_W);

  logic [DEPTH-1:0][EW-1:0] ent;
  logic [DEPTH-1:0]         vld, wake_rs, wake_rt, kill;
  logic [AW-1:0]            head, tail;
  logic [CW-1:0]            count;
  logic [EW-1:0]            hd, new_ent;
  logic                     hd_vld, cdb_en, full, write, issue, drop, pop;

  assign hd     = ent[head];
  assign hd_vld = vld[head];
  assign cdb_en = bus.complete & bus.RegDest_compl;
  assign full   = (count == CW'(DEPTH));
  assign write  = bus.isDispatch & ~bus.stall_hazard & ~full & ~bus.recover
                & (bus.mem_ren | bus.mem_wen);
  assign issue  = ~bus.stall_hazard & ~bus.recover & hd_vld & ~hd[O_KIL]
                & hd[O_VRS] & hd[O_VRT];
  // flushed heads retire silently as soon as recovery lifts
  assign drop   = ~bus.recover & hd_vld & hd[O_KIL];
  assign pop    = issue | drop;

  always_comb begin
    new_ent                   = '0;
    new_ent[OFF_ISLW]         = bus.mem_ren;
    new_ent[OFF_ISST]         = bus.mem_wen;
    new_ent[OFF_ROB +: ROB_W] = bus.rob_num_dp;
    new_ent[O_PRD +: PR_W]    = bus.p_rd_new;
    new_ent[O_PRS +: PR_W]    = bus.p_rs;
    new_ent[O_PRT +: PR_W]    = bus.p_rt;
    new_ent[O_IMM +: IMM_W]   = bus.immed;
    new_ent[O_VRS] = bus.v_rs | ~bus.read_rs | (cdb_en & (bus.p_rd_compl == bus.p_rs));
    new_ent[O_VRT] = bus.v_rt | ~bus.read_rt | (cdb_en & (bus.p_rd_compl == bus.p_rt));
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    lsq_match_cmp #(.ROB_W(ROB_W), .PR_W(PR_W)) u_cmp (
      .vld         (vld[g]),
      .p_rs        (ent[g][O_PRS +: PR_W]),
      .p_rt        (ent[g][O_PRT +: PR_W]),
      .rob         (ent[g][OFF_ROB +: ROB_W]),
      .cdb_en      (cdb_en),
      .p_rd_compl  (bus.p_rd_compl),
      .recover     (bus.recover),
      .rob_num_rec (bus.rob_num_rec),
      .wake_rs     (wake_rs[g]),
      .wake_rt     (wake_rt[g]),
      .kill        (kill[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent   <= '0;
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake_rs[i]) ent[i][O_VRS] <= 1'b1;
        if (wake_rt[i]) ent[i][O_VRT] <= 1'b1;
        if (kill[i]) begin
          ent[i][O_KIL]    <= 1'b1;
          ent[i][OFF_ISLW] <= 1'b0;
          ent[i][OFF_ISST] <= 1'b0;
        end
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + AW'(1);
      end
      // tail slot is never valid when write is allowed, so no wake/kill collision
      if (write) begin
        ent[tail] <= new_ent;
        vld[tail] <= 1'b1;
        tail      <= tail + AW'(1);
      end
      case ({write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.p_rs_out    = hd[O_PRS +: PR_W];
  assign bus.p_rt_out    = hd[O_PRT +: PR_W];
  assign bus.p_rd_out    = hd[O_PRD +: PR_W];
  assign bus.immed_out   = hd[O_IMM +: IMM_W];
  assign bus.rob_num_out = hd[OFF_ROB +: ROB_W];
  assign bus.RegDest_out = hd[OFF_ISLW];
  assign bus.mem_ren_out = hd[OFF_ISLW];
  assign bus.mem_wen_out = hd[OFF_ISST];
  assign bus.issue       = issue;
  assign bus.lss_full    = full;
  assign bus.lss_empty   = (count == '0);
  assign bus.lss_count   = count;
endmodule

// File: tb/tb_lsq_station.sv
// Directed bench: vector table for single-op behaviour plus hand sequences for fill, flush, wrap and reset.
module tb_lsq_station;
  import lsq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsq_station_if #(.DEPTH(8)) ia ();
  lsq_station_if #(.DEPTH(4)) ib ();
  lsq_station #(.DEPTH(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  lsq_station #(.DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct {
    logic dp, ren, wen, rd_rs, v_rs, stall, rec, cmp, regd;
    logic [3:0] rob, rrob;
    logic [5:0] prs, cpr;
  } in_t;

  typedef struct {
    logic rst;
    in_t  i;
    logic chk, iss, empty;
    int   cnt, rob;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic in_t dsp(logic [3:0] rob, logic [5:0] prs, logic rdy, logic ren, logic wen);
    in_t v;
    v = idle();
    v.dp = 1'b1; v.rob = rob; v.prs = prs; v.rd_rs = 1'b1; v.v_rs = rdy;
    v.ren = ren; v.wen = wen;
    return v;
  endfunction

  function automatic in_t cdb(logic [5:0] pr, logic regd);
    in_t v;
    v = idle();
    v.cmp = 1'b1; v.cpr = pr; v.regd = regd;
    return v;
  endfunction

  function automatic void add(logic r, in_t i, logic c, logic iss, int cnt, logic e, int rob);
    vec_t t;
    t.rst = r; t.i = i; t.chk = c; t.iss = iss; t.cnt = cnt; t.empty = e; t.rob = rob;
    tbl.push_back(t);
  endfunction

  task automatic put_a(input in_t v);
    ia.isDispatch = v.dp; ia.rob_num_dp = v.rob; ia.p_rd_new = 6'd1;
    ia.p_rs = v.prs; ia.read_rs = v.rd_rs; ia.v_rs = v.v_rs;
    ia.p_rt = 6'd0; ia.read_rt = 1'b0; ia.v_rt = 1'b0;
    ia.mem_ren = v.ren; ia.mem_wen = v.wen; ia.immed = 16'h0010;
    ia.stall_hazard = v.stall; ia.recover = v.rec; ia.rob_num_rec = v.rrob;
    ia.complete = v.cmp; ia.p_rd_compl = v.cpr; ia.RegDest_compl = v.regd;
  endtask

  task automatic put_b(input in_t v);
    ib.isDispatch = v.dp; ib.rob_num_dp = v.rob; ib.p_rd_new = 6'd2;
    ib.p_rs = v.prs; ib.read_rs = v.rd_rs; ib.v_rs = v.v_rs;
    ib.p_rt = 6'd0; ib.read_rt = 1'b0; ib.v_rt = 1'b0;
    ib.mem_ren = v.ren; ib.mem_wen = v.wen; ib.immed = 16'h0020;
    ib.stall_hazard = v.stall; ib.recover = v.rec; ib.rob_num_rec = v.rrob;
    ib.complete = v.cmp; ib.p_rd_compl = v.cpr; ib.RegDest_compl = v.regd;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t v;
    int t;
    int sz[6] = '{4, 3, 3, 4, 3, 3};

    // r, inputs, chk, iss, cnt, empty, rob
    add(0, idle(),                  1, 0, 0, 1, 0);
    add(0, dsp(3, 5, 0, 0, 1),      1, 0, 0, 1, 0);
    add(0, idle(),                  1, 0, 1, 0, 0);
    add(0, cdb(5, 0),               1, 0, 1, 0, 0);
    add(0, idle(),                  1, 0, 1, 0, 0);
    add(0, cdb(5, 1),               1, 0, 1, 0, 0);
    add(0, idle(),                  1, 1, 1, 0, 3);
    v = dsp(4, 9, 0, 1, 0); v.cmp = 1'b1; v.cpr = 6'd9; v.regd = 1'b1;
    add(0, v,                       1, 0, 0, 1, 0);
    add(0, idle(),                  1, 1, 1, 0, 4);
    add(0, dsp(5, 7, 1, 1, 0),      1, 0, 0, 1, 0);
    v = dsp(6, 7, 1, 1, 0); v.stall = 1'b1;
    add(0, v,                       1, 0, 1, 0, 0);
    add(0, idle(),                  1, 1, 1, 0, 5);
    add(0, dsp(7, 7, 1, 0, 0),      1, 0, 0, 1, 0);
    v = dsp(8, 7, 1, 1, 0); v.rec = 1'b1;
    add(0, v,                       1, 0, 0, 1, 0);
    add(0, idle(),                  1, 0, 0, 1, 0);
    add(0, dsp(9, 7, 1, 1, 0),      1, 0, 0, 1, 0);
    add(1, idle(),                  0, 0, 0, 0, 0);
    add(0, idle(),                  1, 0, 0, 1, 0);

    rst = 1'b1;
    put_a(idle());
    put_b(idle());
    nxt();

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst;
      put_a(tbl[k].i);
      @(negedge clk);
      if (tbl[k].chk) begin
        chk($sformatf("v%0d_issue", k), int'(ia.issue), int'(tbl[k].iss));
        chk($sformatf("v%0d_count", k), int'(ia.lss_count), tbl[k].cnt);
        chk($sformatf("v%0d_empty", k), int'(ia.lss_empty), int'(tbl[k].empty));
        chk($sformatf("v%0d_full", k), int'(ia.lss_full), 0);
        if (tbl[k].iss) chk($sformatf("v%0d_rob", k), int'(ia.rob_num_out), tbl[k].rob);
      end
      nxt();
    end
    rst = 1'b0;

    // fill 8 behind a blocked head, 9th ignored, drain in order; dispatch blocked while full
    for (int i = 0; i < 8; i++) begin
      put_a(dsp(4'(i), (i == 0) ? 6'd20 : 6'd7, (i != 0), 1, 0));
      @(negedge clk);
      chk($sformatf("fill%0d_issue", i), int'(ia.issue), 0);
      chk($sformatf("fill%0d_count", i), int'(ia.lss_count), i);
      nxt();
    end
    put_a(dsp(8, 7, 1, 1, 0));
    @(negedge clk);
    chk("full_flag", int'(ia.lss_full), 1);
    chk("full_count", int'(ia.lss_count), 8);
    nxt();
    put_a(cdb(20, 1));
    @(negedge clk);
    chk("ninth_ignored", int'(ia.lss_count), 8);
    chk("wake_issue_pre", int'(ia.issue), 0);
    nxt();
    put_a(dsp(9, 7, 1, 1, 0));
    @(negedge clk);
    chk("full_iss0", int'(ia.issue), 1);
    chk("full_rob0", int'(ia.rob_num_out), 0);
    nxt();
    for (int i = 1; i < 8; i++) begin
      put_a(idle());
      @(negedge clk);
      if (i == 1) chk("full_blocked_count", int'(ia.lss_count), 7);
      chk($sformatf("drain%0d_issue", i), int'(ia.issue), 1);
      chk($sformatf("drain%0d_rob", i), int'(ia.rob_num_out), i);
      nxt();
    end
    @(negedge clk);
    chk("drain_empty", int'(ia.lss_empty), 1);
    chk("drain_no_issue", int'(ia.issue), 0);
    nxt();

    // flush of a blocked head: dropped even under stall, younger op then issues
    put_a(dsp(1, 21, 0, 1, 0)); nxt();
    put_a(dsp(2, 22, 0, 1, 0)); nxt();
    put_a(dsp(3, 7, 1, 1, 0));  nxt();
    v = idle(); v.rec = 1'b1; v.rrob = 4'd1;
    put_a(v);
    @(negedge clk);
    chk("rec_issue", int'(ia.issue), 0);
    chk("rec_count", int'(ia.lss_count), 3);
    nxt();
    v = idle(); v.stall = 1'b1;
    put_a(v);
    @(negedge clk);
    chk("drop_issue", int'(ia.issue), 0);
    chk("drop_ren_cleared", int'(ia.mem_ren_out), 0);
    nxt();
    put_a(cdb(22, 1));
    @(negedge clk);
    chk("drop_count", int'(ia.lss_count), 2);
    chk("drop_head_blocked", int'(ia.issue), 0);
    nxt();
    put_a(idle());
    @(negedge clk);
    chk("rec_iss2", int'(ia.issue), 1);
    chk("rec_rob2", int'(ia.rob_num_out), 2);
    nxt();
    @(negedge clk);
    chk("rec_iss3", int'(ia.issue), 1);
    chk("rec_rob3", int'(ia.rob_num_out), 3);
    nxt();
    @(negedge clk);
    chk("rec_empty", int'(ia.lss_empty), 1);
    nxt();

    // simultaneous write and issue at count 3
    put_a(dsp(4, 23, 0, 1, 0)); nxt();
    put_a(dsp(5, 7, 1, 1, 0));  nxt();
    put_a(dsp(6, 7, 1, 0, 1));  nxt();
    put_a(cdb(23, 1));
    @(negedge clk);
    chk("c3_count", int'(ia.lss_count), 3);
    nxt();
    put_a(dsp(7, 7, 1, 1, 0));
    @(negedge clk);
    chk("c3_iss", int'(ia.issue), 1);
    chk("c3_rob", int'(ia.rob_num_out), 4);
    nxt();
    put_a(idle());
    @(negedge clk);
    chk("c3_hold", int'(ia.lss_count), 3);
    chk("c3_rob5", int'(ia.rob_num_out), 5);
    nxt();
    @(negedge clk);
    chk("c3_rob6", int'(ia.rob_num_out), 6);
    chk("c3_st", int'(ia.mem_wen_out), 1);
    nxt();
    @(negedge clk);
    chk("c3_rob7", int'(ia.rob_num_out), 7);
    nxt();

    // reset with 5 pending entries, dispatch during reset discarded
    for (int i = 0; i < 5; i++) begin
      put_a(dsp(4'(i), (i == 0) ? 6'd24 : 6'd7, (i != 0), 1, 0));
      nxt();
    end
    rst = 1'b1;
    v = dsp(5, 7, 1, 1, 0); v.cmp = 1'b1; v.cpr = 6'd24; v.regd = 1'b1;
    put_a(v);
    nxt();
    rst = 1'b0;
    put_a(idle());
    @(negedge clk);
    chk("rst_empty", int'(ia.lss_empty), 1);
    chk("rst_count", int'(ia.lss_count), 0);
    chk("rst_issue", int'(ia.issue), 0);
    chk("rst_full", int'(ia.lss_full), 0);
    nxt();

    // DEPTH=4: uneven batches walk the pointers around the ring
    t = 0;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < sz[r]; k++) begin
        put_b(dsp(4'(t + k), (k == 0) ? 6'd30 : 6'd7, (k != 0), 1, 0));
        @(negedge clk);
        chk($sformatf("w%0d_%0d_issue", r, k), int'(ib.issue), 0);
        chk($sformatf("w%0d_%0d_count", r, k), int'(ib.lss_count), k);
        nxt();
      end
      put_b(cdb(30, 1));
      @(negedge clk);
      chk($sformatf("w%0d_full", r), int'(ib.lss_full), int'(sz[r] == 4));
      nxt();
      for (int k = 0; k < sz[r]; k++) begin
        put_b(idle());
        @(negedge clk);
        chk($sformatf("w%0d_%0d_iss", r, k), int'(ib.issue), 1);
        chk($sformatf("w%0d_%0d_rob", r, k), int'(ib.rob_num_out), (t + k) % 16);
        nxt();
      end
      t += sz[r];
    end
    @(negedge clk);
    chk("wrap_empty", int'(ib.lss_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
